// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM encoding and helpers for the ALU response checker.
// Optional first-failure logging is enabled with the ALU_CHK_LOG_EN macro.
package alu_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_XOR = 2'b11;

    localparam int VEC_W = 15;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Counters stop at all-ones instead of wrapping back to zero.
    function automatic logic [7:0] satInc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of the 4-bit ALU under check.
// It produces the expected result and flag for each operation.
module alu_ref_model
    import alu_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [1:0] sel,
    output logic [3:0] exp_y,
    output logic       exp_z
);

    logic [4:0] sum;

    // The ADD flag is the carry out; the SUB flag is the borrow (a < b).
    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        exp_y = 4'd0;
        exp_z = 1'b0;
        case (sel)
            ALU_ADD: begin
                exp_y = sum[3:0];
                exp_z = sum[4];
            end
            ALU_SUB: begin
                exp_y = a - b;
                exp_z = (a < b);
            end
            ALU_AND: begin
                exp_y = a & b;
                exp_z = ((a & b) == 4'd0);
            end
            default: begin
                exp_y = a ^ b;
                exp_z = ((a ^ b) == 4'd0);
            end
        endcase
    end

endmodule

// File: rtl/alu_resp_checker.sv
// Checks a run of N_VEC ALU response vectors against the golden model and tallies results.
// Define ALU_CHK_LOG_EN to capture the first failing vector on fail_vec.
module alu_resp_checker
    import alu_pkg::*;
#(
    parameter int N_VEC = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             vld,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    input  logic [1:0]       sel,
    input  logic [3:0]       y,
    input  logic             z,
    output logic [7:0]       pass_cnt,
    output logic [7:0]       fail_cnt,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [7:0]       first_fail_idx,
    output logic [VEC_W-1:0] fail_vec
);

    localparam logic [7:0] LAST_IDX = 8'(N_VEC - 1);

    state_t     state_q;
    logic [7:0] idx_q;
    logic [7:0] passCnt_q;
    logic [7:0] failCnt_q;
    logic [7:0] firstFailIdx_q;
    logic       err_q;
    logic       busy_q;
    logic       done_q;

    logic [7:0] passCnt_d;
    logic [7:0] failCnt_d;
    logic [3:0] expY;
    logic       expZ;
    logic       match;
    logic       accept;
    logic       lastVec;

    alu_ref_model u_ref (
        .a     (a),
        .b     (b),
        .sel   (sel),
        .exp_y (expY),
        .exp_z (expZ)
    );

    // A start pulse always wins, so any vector presented alongside it is dropped.
    assign accept    = (state_q == RUN) && vld && !start;
    assign lastVec   = (idx_q == LAST_IDX);
    assign match     = (y == expY) && (z == expZ);
    assign passCnt_d = satInc8(passCnt_q);
    assign failCnt_d = satInc8(failCnt_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            idx_q          <= 8'd0;
            passCnt_q      <= 8'd0;
            failCnt_q      <= 8'd0;
            firstFailIdx_q <= 8'd0;
            err_q          <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else if (start) begin
            state_q        <= RUN;
            idx_q          <= 8'd0;
            passCnt_q      <= 8'd0;
            failCnt_q      <= 8'd0;
            firstFailIdx_q <= 8'd0;
            err_q          <= 1'b0;
            busy_q         <= 1'b1;
            done_q         <= 1'b0;
        end else if (accept) begin
            idx_q <= idx_q + 8'd1;
            if (match) begin
                passCnt_q <= passCnt_d;
            end else begin
                failCnt_q <= failCnt_d;
                if (!err_q) begin
                    err_q          <= 1'b1;
                    firstFailIdx_q <= idx_q;
                end
            end
            // Final counts and the DONE state become visible on the same edge.
            if (lastVec) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
            end
        end
    end

`ifdef ALU_CHK_LOG_EN
    logic [VEC_W-1:0] failVec_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            failVec_q <= '0;
        end else if (start) begin
            failVec_q <= '0;
        end else if (accept && !match && !err_q) begin
            failVec_q <= {a, b, sel, y, z};
        end
    end

    assign fail_vec = failVec_q;
`else
    assign fail_vec = '0;
`endif

    assign pass_cnt       = passCnt_q;
    assign fail_cnt       = failCnt_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign first_fail_idx = firstFailIdx_q;

endmodule

// File: tb/tb_alu_resp_checker.sv
// Directed self-checking bench for alu_resp_checker using three run lengths (2, 16, 255).
// Expected fail_vec follows whether ALU_CHK_LOG_EN is defined for the build.
module tb_alu_resp_checker;

    logic       clk;
    logic       rst;
    logic       start;
    logic       vld;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] sel;
    logic [3:0] y;
    logic       z;

    logic [7:0]  pass2, fail2, ffi2;
    logic        busy2, done2, err2;
    logic [14:0] fv2;
    logic [7:0]  pass16, fail16, ffi16;
    logic        busy16, done16, err16;
    logic [14:0] fv16;
    logic [7:0]  pass255, fail255, ffi255;
    logic        busy255, done255, err255;
    logic [14:0] fv255;

    int checks = 0;
    int errors = 0;

    alu_resp_checker #(.N_VEC(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .vld(vld), .a(a), .b(b), .sel(sel), .y(y), .z(z),
        .pass_cnt(pass2), .fail_cnt(fail2), .busy(busy2), .done(done2), .err(err2),
        .first_fail_idx(ffi2), .fail_vec(fv2)
    );

    alu_resp_checker #(.N_VEC(16)) dut16 (
        .clk(clk), .rst(rst), .start(start), .vld(vld), .a(a), .b(b), .sel(sel), .y(y), .z(z),
        .pass_cnt(pass16), .fail_cnt(fail16), .busy(busy16), .done(done16), .err(err16),
        .first_fail_idx(ffi16), .fail_vec(fv16)
    );

    alu_resp_checker #(.N_VEC(255)) dut255 (
        .clk(clk), .rst(rst), .start(start), .vld(vld), .a(a), .b(b), .sel(sel), .y(y), .z(z),
        .pass_cnt(pass255), .fail_cnt(fail255), .busy(busy255), .done(done255), .err(err255),
        .first_fail_idx(ffi255), .fail_vec(fv255)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs just after an edge, then sample 1 time unit after the next edge.
    task automatic applyStimulus(input logic st, input logic v, input logic [3:0] ai,
                                 input logic [3:0] bi, input logic [1:0] si,
                                 input logic [3:0] yi, input logic zi);
        start = st;
        vld   = v;
        a     = ai;
        b     = bi;
        sel   = si;
        y     = yi;
        z     = zi;
        @(posedge clk);
        #1;
        start = 1'b0;
        vld   = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [14:0] expVecA;
    logic [14:0] expVecB;

    initial begin
`ifdef ALU_CHK_LOG_EN
        expVecA = {4'h1, 4'hF, 2'b01, 4'h3, 1'b1};
        expVecB = {4'h7, 4'h7, 2'b11, 4'h0, 1'b0};
`else
        expVecA = 15'd0;
        expVecB = 15'd0;
`endif
        rst = 1'b1; start = 1'b0; vld = 1'b0;
        a = 4'h0; b = 4'h0; sel = 2'b00; y = 4'h0; z = 1'b0;
        #2;
        checkOutput("reset_pass", pass2, 0);
        checkOutput("reset_fail", fail2, 0);
        checkOutput("reset_busy", busy2, 0);
        checkOutput("reset_done", done2, 0);
        checkOutput("reset_err", err2, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] vld in IDLE and start+vld in IDLE");
        applyStimulus(0, 1, 4'h1, 4'h1, 2'b00, 4'h2, 1'b0);
        checkOutput("idle_vld_pass", pass2, 0);
        checkOutput("idle_vld_busy", busy2, 0);
        applyStimulus(1, 1, 4'h1, 4'h1, 2'b00, 4'h2, 1'b0);
        checkOutput("start_vld_busy", busy2, 1);
        checkOutput("start_vld_pass", pass2, 0);

        $display("[TB] two matching vectors ADD and AND");
        applyStimulus(0, 1, 4'hF, 4'hF, 2'b00, 4'hE, 1'b1);
        checkOutput("add_pass", pass2, 1);
        checkOutput("add_busy", busy2, 1);
        applyStimulus(0, 1, 4'hA, 4'h5, 2'b10, 4'h0, 1'b1);
        checkOutput("and_pass", pass2, 2);
        checkOutput("and_fail", fail2, 0);
        checkOutput("and_err", err2, 0);
        checkOutput("and_done", done2, 1);
        checkOutput("and_busy", busy2, 0);
        applyStimulus(0, 1, 4'h1, 4'h1, 2'b01, 4'h7, 1'b1);
        checkOutput("done_vld_pass", pass2, 2);
        checkOutput("done_vld_fail", fail2, 0);
        checkOutput("done_hold", done2, 1);

        $display("[TB] SUB pass then SUB fail at index 1");
        applyStimulus(1, 0, 4'h0, 4'h0, 2'b00, 4'h0, 1'b0);
        checkOutput("restart_pass", pass2, 0);
        checkOutput("restart_done", done2, 0);
        checkOutput("restart_busy", busy2, 1);
        applyStimulus(0, 1, 4'h1, 4'hF, 2'b01, 4'h2, 1'b1);
        checkOutput("sub_ok_pass", pass2, 1);
        checkOutput("sub_ok_err", err2, 0);
        applyStimulus(0, 1, 4'h1, 4'hF, 2'b01, 4'h3, 1'b1);
        checkOutput("sub_bad_fail", fail2, 1);
        checkOutput("sub_bad_err", err2, 1);
        checkOutput("sub_bad_ffi", ffi2, 1);
        checkOutput("sub_bad_vec", fv2, expVecA);
        checkOutput("sub_bad_done", done2, 1);

        $display("[TB] XOR wrong flag then later mismatch");
        applyStimulus(1, 0, 4'h0, 4'h0, 2'b00, 4'h0, 1'b0);
        checkOutput("clear_err", err2, 0);
        checkOutput("clear_vec", fv2, 0);
        applyStimulus(0, 1, 4'h7, 4'h7, 2'b11, 4'h0, 1'b0);
        checkOutput("xor_fail", fail2, 1);
        checkOutput("xor_ffi", ffi2, 0);
        checkOutput("xor_vec", fv2, expVecB);
        applyStimulus(0, 1, 4'h1, 4'h1, 2'b00, 4'h3, 1'b0);
        checkOutput("second_fail", fail2, 2);
        checkOutput("second_ffi", ffi2, 0);
        checkOutput("second_vec", fv2, expVecB);
        checkOutput("second_pass", pass2, 0);

        $display("[TB] start during RUN discards coincident vector");
        applyStimulus(1, 0, 4'h0, 4'h0, 2'b00, 4'h0, 1'b0);
        applyStimulus(0, 1, 4'h3, 4'h4, 2'b00, 4'h7, 1'b0);
        checkOutput("run_one_pass", pass2, 1);
        applyStimulus(1, 1, 4'h3, 4'h4, 2'b00, 4'h7, 1'b0);
        checkOutput("run_restart_pass", pass2, 0);
        checkOutput("run_restart_busy", busy2, 1);
        applyStimulus(0, 1, 4'h6, 4'h3, 2'b10, 4'h2, 1'b0);
        checkOutput("after_restart_pass", pass2, 1);
        checkOutput("after_restart_done", done2, 0);
        applyStimulus(0, 1, 4'h9, 4'h6, 2'b11, 4'hF, 1'b0);
        checkOutput("after_restart_fin", pass2, 2);
        checkOutput("after_restart_dn", done2, 1);

        $display("[TB] reset mid-run on the 16-vector checker");
        applyStimulus(1, 0, 4'h0, 4'h0, 2'b00, 4'h0, 1'b0);
        applyStimulus(0, 1, 4'h2, 4'h3, 2'b00, 4'h5, 1'b0);
        applyStimulus(0, 1, 4'h3, 4'hC, 2'b10, 4'h1, 1'b1);
        applyStimulus(0, 1, 4'h5, 4'hA, 2'b11, 4'hF, 1'b0);
        checkOutput("mid_pass", pass16, 2);
        checkOutput("mid_fail", fail16, 1);
        checkOutput("mid_ffi", ffi16, 1);
        checkOutput("mid_busy", busy16, 1);
        rst = 1'b1;
        #2;
        checkOutput("rst_pass", pass16, 0);
        checkOutput("rst_fail", fail16, 0);
        checkOutput("rst_err", err16, 0);
        checkOutput("rst_ffi", ffi16, 0);
        checkOutput("rst_busy", busy16, 0);
        checkOutput("rst_done", done16, 0);
        checkOutput("rst_vec", fv16, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1, 0, 4'h0, 4'h0, 2'b00, 4'h0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 1, 4'h0, 4'h0, 2'b10, 4'h0, 1'b1);
        end
        checkOutput("clean_pass", pass16, 16);
        checkOutput("clean_fail", fail16, 0);
        checkOutput("clean_done", done16, 1);

        $display("[TB] full 255-vector run");
        applyStimulus(1, 0, 4'h0, 4'h0, 2'b00, 4'h0, 1'b0);
        for (int i = 0; i < 254; i++) begin
            applyStimulus(0, 1, 4'(i), 4'h0, 2'b00, 4'(i), 1'b0);
        end
        checkOutput("long_pass_254", pass255, 254);
        checkOutput("long_busy_254", busy255, 1);
        checkOutput("long_done_254", done255, 0);
        applyStimulus(0, 1, 4'h4, 4'h2, 2'b01, 4'h2, 1'b0);
        checkOutput("long_pass_255", pass255, 255);
        checkOutput("long_done_255", done255, 1);
        applyStimulus(0, 1, 4'h4, 4'h2, 2'b01, 4'h2, 1'b0);
        applyStimulus(0, 1, 4'h4, 4'h2, 2'b01, 4'h2, 1'b0);
        checkOutput("long_pass_hold", pass255, 255);
        checkOutput("long_fail_hold", fail255, 0);
        checkOutput("long_done_hold", done255, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_resp_checker.md
ALU_RESP_CHECKER -- requirements
Module: alu_resp_checker

Interface
REQ-001 SHALL have parameter N_VEC, default 16, meaning the number of vectors per run (range 1..255).
REQ-002 SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, meaning asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit, meaning a one-cycle pulse that begins a new run.
REQ-005 SHALL have port vld, input, 1 bit, meaning a,b,sel,y,z are valid and form one vector this cycle.
REQ-006 SHALL have ports a and b, each input, 4 bits, meaning the ALU operands applied.
REQ-007 SHALL have port sel, input, 2 bits, meaning the ALU operation select applied.
REQ-008 SHALL have ports y (input, 4 bits) and z (input, 1 bit), meaning the ALU result and flag under check.
REQ-009 SHALL have ports pass_cnt and fail_cnt, each output, 8 bits, meaning matching and mismatching vector counts.
REQ-010 SHALL have port busy, output, 1 bit, meaning the run is in progress.
REQ-011 SHALL have port done, output, 1 bit, meaning the run is complete.
REQ-012 SHALL have port err, output, 1 bit, meaning a sticky flag for any mismatch in the current run.
REQ-013 SHALL have port first_fail_idx, output, 8 bits, meaning the vector index of the first mismatch.
REQ-014 SHALL have port fail_vec, output, 15 bits, meaning the logged first failing vector {a,b,sel,y,z}.

Function
REQ-015 SHALL compute the expected result from the golden model as follows:
- sel 00 ADD: y=(a+b)[3:0], z=carry out.
- sel 01 SUB: y=(a-b)[3:0], z=1 iff a<b.
- sel 10 AND: y=a&b, z=(y==0).
- sel 11 XOR: y=a^b, z=(y==0).
REQ-016 SHALL implement FSM states IDLE, RUN and DONE, and enter IDLE on reset.
REQ-017 SHALL make these transitions:
- IDLE -start-> RUN.
- RUN -(vector N_VEC-1 accepted)-> DONE.
- DONE -start-> RUN.
REQ-018 SHALL, on entering RUN, clear pass_cnt, fail_cnt, err, first_fail_idx, fail_vec, the vector index and done.
REQ-019 SHALL accept one vector per cycle in RUN when vld=1, and ignore vld in IDLE and DONE.
REQ-020 SHALL register each compare, so the counters, err and first_fail_idx update exactly 1 cycle after the vld cycle.
REQ-021 SHALL treat a vector as matching only if both y and z equal the expected values.
REQ-022 SHALL assert busy=1 only in RUN, and hold done=1 in DONE until the next start.
REQ-023 SHALL record first_fail_idx only on the first mismatch of a run, and not overwrite it afterwards.
REQ-024 SHALL saturate pass_cnt and fail_cnt at 255 with no wrap.
REQ-025 SHALL, when start=1 during RUN, restart the run and discard any vld in that same cycle.
REQ-026 SHALL, when start and vld coincide in IDLE or DONE, only start the run; that vector is not counted.
REQ-027 SHALL move to DONE in the cycle after the final vector, with the final counts visible in that same cycle.

Reset
REQ-028 SHALL, on rst, asynchronously clear all outputs and registers to 0, with the FSM in IDLE.
REQ-029 SHALL, on rst mid-run, abandon the run with no partial results retained.

Configuration
REQ-030 SHALL, with ALU_CHK_LOG_EN defined, capture {a,b,sel,y,z} of the first mismatch into fail_vec, written under the same condition as first_fail_idx.
REQ-031 SHALL, without ALU_CHK_LOG_EN, drive fail_vec constant 0 and infer no log register.

Structure
REQ-032 SHALL place the opcode constants (ALU_ADD=00, ALU_SUB=01, ALU_AND=10, ALU_XOR=11) and the FSM state encoding in the shared package alu_pkg.
REQ-033 SHALL implement the golden model as the combinational sub-module alu_ref_model, with inputs a, b, sel and outputs exp_y, exp_z.

Verification
REQ-034 SHALL cover: N_VEC=2, start, ADD a=F b=F y=E z=1, then AND a=A b=5 y=0 z=1 -> pass_cnt=2, fail_cnt=0, err=0, done=1.
REQ-035 SHALL cover: SUB a=1 b=F y=2 z=1 -> pass; then SUB a=1 b=F y=3 z=1 as vector index 1 -> fail_cnt=1, err=1, first_fail_idx=1, fail_vec={1,F,01,3,1} with ALU_CHK_LOG_EN defined, 0 without.
REQ-036 SHALL cover: XOR a=7 b=7 with y=0 z=0 (z is wrong) -> mismatch counted; a later mismatch leaves first_fail_idx unchanged.
REQ-037 SHALL cover: vld pulses in IDLE and DONE, and start coinciding with vld -> counters unchanged.
REQ-038 SHALL cover: rst asserted after 3 of 16 vectors -> all outputs 0 immediately with no clock edge; a new start runs cleanly.
REQ-039 SHALL cover: N_VEC=255 with 255 matching vectors -> pass_cnt=255 held, no wrap, done=1.
